message_collector: RTL
======================

MESSAGE_COLLECTOR -- requirements
Module: message_collector

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 8, meaning the width of one decrypted character.
REQ-002 The block SHALL have parameter DEPTH, default 32, meaning the buffer capacity in characters (power of two, 4..256).
REQ-003 The block SHALL have parameter END_CHAR, default 8'hFA, meaning the end-of-message terminator.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have port clk, input, 1, system clock.
REQ-006 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port data_i, input, DWIDTH, decrypted character from the decryption top output.
REQ-008 The block SHALL have port valid_i, input, 1, data_i qualifier, one character per high cycle.
REQ-009 The block SHALL have port data_o, output, DWIDTH, buffered character to the consumer.
REQ-010 The block SHALL have port valid_o, output, 1, data_o qualifier.
REQ-011 The block SHALL have port ready_i, input, 1, consumer accept; a transfer occurs when valid_o and ready_i are both high.
REQ-012 The block SHALL have port last_o, output, 1, marks the final character of a message.
REQ-013 The block SHALL have port len_o, output, clog2(DEPTH)+1, length of the message being drained.
REQ-014 The block SHALL have port busy, output, 1, high while draining.
REQ-015 The block SHALL have port error, output, 1, sticky flag for dropped characters.
REQ-016 The block SHALL have port err_clr, input, 1, clears error.

Function
REQ-017 The block SHALL implement states IDLE, COLLECT and DRAIN.
REQ-018 In IDLE, a valid_i with data_i != END_CHAR SHALL store the character at address 0, set the count to 1 and move to COLLECT.
REQ-019 In IDLE, a valid_i with data_i == END_CHAR SHALL be ignored: no state change and no error.
REQ-020 In COLLECT, a valid_i with a non-terminator SHALL store the character at the write pointer and increment the pointer and count.
REQ-021 In COLLECT, a valid_i with data_i == END_CHAR SHALL not be stored, SHALL latch count into len_o, and SHALL move to DRAIN.
REQ-022 When count == DEPTH in COLLECT, a non-terminator character SHALL be dropped and error set; the state SHALL remain COLLECT.
REQ-023 In DRAIN, valid_o SHALL be high from the cycle after the terminator is accepted (1-cycle latency) until the last transfer.
REQ-024 data_o SHALL present buffer characters in arrival order; the read pointer SHALL advance only on a transfer.
REQ-025 data_o SHALL hold its value while valid_o is high and ready_i is low.
REQ-026 data_o SHALL be 0 whenever valid_o is low.
REQ-027 last_o SHALL be high exactly when valid_o is high and the read pointer equals len_o-1.
REQ-028 On a transfer with last_o high, the block SHALL clear pointers and count, drop valid_o the next cycle, and return to IDLE.
REQ-029 A character arriving in that IDLE cycle SHALL be accepted normally.
REQ-030 busy SHALL be high exactly in DRAIN.
REQ-031 Any valid_i during DRAIN SHALL be dropped and error set.
REQ-032 len_o SHALL hold its latched value through DRAIN and SHALL read 0 in IDLE and COLLECT.
REQ-033 error SHALL clear on err_clr; if err_clr coincides with a new drop event, the set SHALL win.
REQ-034 ready_i SHALL be ignored when valid_o is low.

Reset
REQ-035 When rst is high at a clk edge, the block SHALL go to IDLE, clear pointers and count, and drive valid_o=0, data_o=0, last_o=0, len_o=0, busy=0, error=0.
REQ-036 Reset SHALL take priority over all other inputs, including mid-COLLECT or mid-DRAIN; buffered characters SHALL be discarded.
REQ-037 Buffer RAM contents SHALL need no reset.

Verification
REQ-038 Feed 0x48,0x49,0xFA with ready_i=1 -> valid_o the cycle after 0xFA, data_o 0x48 then 0x49, last_o on 0x49, len_o=2, then IDLE.
REQ-039 Same message with ready_i low 3 cycles then high -> data_o held at 0x48 while stalled, no loss, busy=1 throughout DRAIN.
REQ-040 Feed 33 non-terminator characters then 0xFA (DEPTH=32) -> 33rd dropped, error=1, len_o=32, 32 characters drained.
REQ-041 valid_i with 0x41 during DRAIN -> error=1, drained output unchanged; err_clr pulse -> error=0.
REQ-042 Lone 0xFA in IDLE -> no state change, valid_o stays 0; rst asserted mid-DRAIN -> all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/message_collector.sv
// Collects decrypted characters until the end-of-message terminator, then drains
// the buffered message to a valid/ready consumer with last/length side-band.
module message_collector #(
  parameter int                DWIDTH   = 8,
  parameter int                DEPTH    = 32,
  parameter logic [DWIDTH-1:0] END_CHAR = DWIDTH'(8'hFA)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DWIDTH-1:0]          data_i,
  input  logic                       valid_i,
  output logic [DWIDTH-1:0]          data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic                       last_o,
  output logic [$clog2(DEPTH):0]     len_o,
  output logic                       busy,
  output logic                       error,
  input  logic                       err_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [DWIDTH-1:0] mem [DEPTH];
  // count doubles as the write pointer: characters are stored densely from 0
  logic [CW-1:0]     count;
  logic [CW-1:0]     rd_ptr;
  logic [CW-1:0]     len_q;

  logic is_term, full, xfer, done;
  logic wr_en, drop, latch;

  assign is_term = (data_i == END_CHAR);
  assign full    = (count == CW'(DEPTH));
  assign valid_o = (state == DRAIN);
  assign busy    = valid_o;
  assign last_o  = valid_o && (rd_ptr == len_q - CW'(1));
  assign xfer    = valid_o && ready_i;
  assign done    = xfer && last_o;
  assign data_o  = valid_o ? mem[rd_ptr[AW-1:0]] : '0;
  assign len_o   = valid_o ? len_q : '0;

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    drop      = 1'b0;
    latch     = 1'b0;
    case (state)
      IDLE: begin
        if (valid_i && !is_term) begin
          wr_en     = 1'b1;
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (valid_i) begin
          if (is_term) begin
            latch     = 1'b1;
            state_nxt = DRAIN;
          end else if (full) begin
            drop = 1'b1;
          end else begin
            wr_en = 1'b1;
          end
        end
      end
      DRAIN: begin
        drop = valid_i;
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      rd_ptr <= '0;
      len_q  <= '0;
      error  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (wr_en) count  <= count + CW'(1);
      if (latch) len_q  <= count;
      if (xfer)  rd_ptr <= rd_ptr + CW'(1);
      if (done) begin
        count  <= '0;
        rd_ptr <= '0;
        len_q  <= '0;
      end
      // a new drop outranks a simultaneous clear
      if (drop)         error <= 1'b1;
      else if (err_clr) error <= 1'b0;
    end
  end

  // buffer storage carries no reset; stale contents are never read
  always_ff @(posedge clk) begin
    if (wr_en) mem[count[AW-1:0]] <= data_i;
  end

endmodule
